// File: rtl/ex_stage_unit.sv
// Execute stage: forwarding muxes, ALU, branch target adder and a multi-cycle
// multiplier. Drives the EX/MEM pipeline register. A multiply holds ID/EX through
// ex_busy and writes bubbles until the product is ready.

module ex_stage_unit #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_src,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic        mem_to_reg,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic        reg_write,
    input  logic [31:0] nextpc,
    input  logic [31:0] rd_data1,
    input  logic [31:0] rd_data2,
    input  logic [31:0] sgn_ext_imm,
    input  logic [4:0]  dest_reg,
    input  logic [1:0]  fwd_a,
    input  logic [1:0]  fwd_b,
    input  logic [31:0] exmem_fwd_val,
    input  logic [31:0] wb_fwd_val,
    input  logic        stall_in,
    input  logic        flush,
    output logic        ex_busy,
    output logic [31:0] alu_result_out,
    output logic [31:0] write_data_out,
    output logic [31:0] branch_target_out,
    output logic        zero_out,
    output logic        mem_to_reg_out,
    output logic        mem_write_out,
    output logic        mem_read_out,
    output logic        reg_write_out,
    output logic [4:0]  dest_reg_out
);

    localparam int unsigned CntW = $clog2(MUL_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MUL_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnSlt  = 6'h2A;
    localparam logic [5:0] FnMult = 6'h18;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;

    // Operands and controls captured when a multiply enters, so forwarding
    // sources may change while it runs.
    logic [31:0] mul_a_q;
    logic [31:0] mul_b_q;
    logic [31:0] mul_wd_q;
    logic [31:0] mul_bt_q;
    logic        mul_mem_to_reg_q;
    logic        mul_mem_write_q;
    logic        mul_mem_read_q;
    logic        mul_reg_write_q;
    logic [4:0]  mul_dest_q;

    logic [31:0] op_a;
    logic [31:0] op_bf;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] branch_tgt;
    logic [31:0] mul_prod;
    logic        mul_start;
    logic        mul_done;

    // Forwarding muxes for operand A and the register-sourced operand B.
    always_comb begin
        case (fwd_a)
            2'b01:   op_a = wb_fwd_val;
            2'b10:   op_a = exmem_fwd_val;
            default: op_a = rd_data1;
        endcase
        case (fwd_b)
            2'b01:   op_bf = wb_fwd_val;
            2'b10:   op_bf = exmem_fwd_val;
            default: op_bf = rd_data2;
        endcase
        op_b = alu_src ? sgn_ext_imm : op_bf;
    end

    // Single-cycle ALU; mult is handled by the FSM, so it yields 0 here.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b11: alu_res = op_a | op_b;
            default: begin
                case (funct)
                    FnAdd:   alu_res = op_a + op_b;
                    FnSub:   alu_res = op_a - op_b;
                    FnAnd:   alu_res = op_a & op_b;
                    FnOr:    alu_res = op_a | op_b;
                    FnSlt:   alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

    // Branch target, product and FSM handshake terms.
    always_comb begin
        branch_tgt = nextpc + {sgn_ext_imm[29:0], 2'b00};
        // Low 32 bits of a product are identical for signed and unsigned operands.
        mul_prod   = mul_a_q * mul_b_q;
        mul_start  = (state_q == StIdle) && (alu_op == 2'b10) && (funct == FnMult) &&
                     !flush && !stall_in;
        // The final MUL cycle is the one whose decrement brings the counter to 0.
        mul_done   = (state_q == StMul) && (cnt_q == CntOne) && !stall_in;
        ex_busy    = (state_q == StMul) || mul_start;
    end

    // FSM, multiply latches and the EX/MEM register, in priority order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            cnt_q             <= '0;
            mul_a_q           <= '0;
            mul_b_q           <= '0;
            mul_wd_q          <= '0;
            mul_bt_q          <= '0;
            mul_mem_to_reg_q  <= 1'b0;
            mul_mem_write_q   <= 1'b0;
            mul_mem_read_q    <= 1'b0;
            mul_reg_write_q   <= 1'b0;
            mul_dest_q        <= '0;
            alu_result_out    <= '0;
            write_data_out    <= '0;
            branch_target_out <= '0;
            zero_out          <= 1'b0;
            mem_to_reg_out    <= 1'b0;
            mem_write_out     <= 1'b0;
            mem_read_out      <= 1'b0;
            reg_write_out     <= 1'b0;
            dest_reg_out      <= '0;
        end else if (flush) begin
            // Squash: bubble out, abort any multiply in progress.
            state_q           <= StIdle;
            cnt_q             <= '0;
            alu_result_out    <= '0;
            write_data_out    <= '0;
            branch_target_out <= '0;
            zero_out          <= 1'b0;
            mem_to_reg_out    <= 1'b0;
            mem_write_out     <= 1'b0;
            mem_read_out      <= 1'b0;
            reg_write_out     <= 1'b0;
            dest_reg_out      <= '0;
        end else if (stall_in) begin
            // Hold EX/MEM and freeze the counter.
        end else if (state_q == StMul) begin
            if (mul_done) begin
                state_q           <= StIdle;
                cnt_q             <= '0;
                alu_result_out    <= mul_prod;
                write_data_out    <= mul_wd_q;
                branch_target_out <= mul_bt_q;
                zero_out          <= (mul_prod == '0);
                mem_to_reg_out    <= mul_mem_to_reg_q;
                mem_write_out     <= mul_mem_write_q;
                mem_read_out      <= mul_mem_read_q;
                reg_write_out     <= mul_reg_write_q;
                dest_reg_out      <= mul_dest_q;
            end else begin
                cnt_q             <= cnt_q - CntOne;
                alu_result_out    <= '0;
                write_data_out    <= '0;
                branch_target_out <= '0;
                zero_out          <= 1'b0;
                mem_to_reg_out    <= 1'b0;
                mem_write_out     <= 1'b0;
                mem_read_out      <= 1'b0;
                reg_write_out     <= 1'b0;
                dest_reg_out      <= '0;
            end
        end else if (mul_start) begin
            // Entry cycle also writes a bubble.
            state_q           <= StMul;
            cnt_q             <= CntLoad;
            mul_a_q           <= op_a;
            mul_b_q           <= op_b;
            mul_wd_q          <= op_bf;
            mul_bt_q          <= branch_tgt;
            mul_mem_to_reg_q  <= mem_to_reg;
            mul_mem_write_q   <= mem_write;
            mul_mem_read_q    <= mem_read;
            mul_reg_write_q   <= reg_write;
            mul_dest_q        <= dest_reg;
            alu_result_out    <= '0;
            write_data_out    <= '0;
            branch_target_out <= '0;
            zero_out          <= 1'b0;
            mem_to_reg_out    <= 1'b0;
            mem_write_out     <= 1'b0;
            mem_read_out      <= 1'b0;
            reg_write_out     <= 1'b0;
            dest_reg_out      <= '0;
        end else begin
            alu_result_out    <= alu_res;
            write_data_out    <= op_bf;
            branch_target_out <= branch_tgt;
            zero_out          <= (alu_res == '0);
            mem_to_reg_out    <= mem_to_reg;
            mem_write_out     <= mem_write;
            mem_read_out      <= mem_read;
            reg_write_out     <= reg_write;
            dest_reg_out      <= dest_reg;
        end
    end

endmodule
